// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes, parity helper.
package ps2_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StInhibit,
        StRts,
        StStart,
        StData,
        StParity,
        StStop,
        StAck,
        StWaitIdle
    } tx_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_fall.sv
// 2-flop synchronizer for WIDTH raw lines (reset to idle-high) plus a falling-edge
// pulse for bit 0, which is the PS/2 clock line by convention.
module ps2_sync_fall #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dsync,
    output logic             fall
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic             prev_q, prev_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '1;
            s2_q   <= '1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign dsync = s2_q;
    assign fall  = prev_q & ~s2_q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter driving open-drain lines via active-high pull-low enables.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a stalled frame.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout
);

    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    logic [1:0] line_sync;
    logic       clk_fall;
    logic       data_sync;

    ps2_sync_fall #(
        .WIDTH(2)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  ({ps2_data, ps2_clk}),
        .dsync(line_sync),
        .fall (clk_fall)
    );

    assign data_sync = line_sync[1];

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            par_q, par_d;
    logic [2:0]      idx_q, idx_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            done_q, done_d;
    logic            ack_q, ack_d;
`ifdef PS2_TX_TIMEOUT_EN
    logic            err_q, err_d;
    logic            watched;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        byte_d    = byte_q;
        par_d     = par_q;
        idx_d     = idx_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        ack_d     = ack_q;
`ifdef PS2_TX_TIMEOUT_EN
        err_d     = err_q;
        watched   = state_q inside {StStart, StData, StParity, StStop, StAck, StWaitIdle};
`endif
        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    byte_d  = tx_data;
                    par_d   = odd_parity(tx_data);
                    ack_d   = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = StInhibit;
                end
            end
            // One cycle short: the RTS cycle also holds the clock low.
            StInhibit: begin
                data_oe_d = 1'b0;
                if (cnt_q == CntW'(INHIBIT_CYCLES - 2)) begin
                    data_oe_d = 1'b1;
                    state_d   = StRts;
                end
            end
            StRts: state_d = StStart;
            StStart: begin
                if (clk_fall) begin
                    data_oe_d = ~byte_q[0];
                    idx_d     = 3'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (clk_fall) begin
                    if (idx_q != 3'd7) begin
                        idx_d     = idx_q + 3'd1;
                        data_oe_d = ~byte_q[idx_q+3'd1];
                    end else begin
                        data_oe_d = ~par_q;
                        state_d   = StParity;
                    end
                end
            end
            StParity: begin
                if (clk_fall) begin
                    data_oe_d = 1'b0;
                    state_d   = StStop;
                end
            end
            StStop: if (clk_fall) state_d = StAck;
            StAck: begin
                if (clk_fall) begin
                    ack_d   = ~data_sync;
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (line_sync == 2'b11) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        if (watched && !clk_fall && cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = StIdle;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            ack_d     = 1'b0;
            err_d     = 1'b1;
        end
`endif

        // Shared counter: inhibit timer, and watchdog cleared on every fall / state change.
        if (state_d == state_q) begin
            if (state_q == StInhibit) cnt_d = cnt_q + 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
            if (watched && !clk_fall) cnt_d = cnt_q + 1'b1;
`endif
        end

        clk_oe_d = (state_d == StInhibit) || (state_d == StRts);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            byte_q    <= '0;
            par_q     <= 1'b0;
            idx_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            idx_q     <= idx_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign tx_ready    = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign ack_ok      = ack_q;

endmodule
